cache_control_nway: RTL
=======================

# cache_control_nway

Parametrised control FSM for a WAYS-way set-associative, write-back, write-allocate cache sitting between the CPU memory port and physical memory. It drives the cache datapath's array write enables, address/data muxes and way selection, and performs victim selection that prefers invalid ways over the LRU way. It adds an explicit flush mode that walks every set/way and writes back all dirty lines.

## Interface
- WAYS, 2: associativity; legal values 2, 4, 8. W = $clog2(WAYS).
- SET_BITS, 3: set-index width; the flush walk covers 2**SET_BITS sets.

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read / mem_write  in  1 each  CPU request; held until mem_resp
- mem_resp  out  1  request complete, one-cycle pulse
- flush  in  1  flush request; sampled only in S_IDLE
- flush_done  out  1  one-cycle pulse when the flush walk ends
- hit  in  WAYS  per-way tag match for the addressed set
- valid / dirty  in  WAYS each  valid/dirty bits of the addressed set
- lru_victim  in  W  LRU way of the addressed set
- way_sel  out  W  way driving the datapath tag/data readout muxes and the LRU update
- set_sel  out  1  0 = CPU set index, 1 = flush_set
- flush_set  out  SET_BITS  flush walk set index
- addressmux_sel  out  2  00 = CPU address, 01 = {tag[way_sel], CPU set}, 10 = {tag[way_sel], flush_set}
- datainmux_sel  out  1  1 = CPU write data merged, 0 = pmem line
- data_write, tag_write, valid_write, dirty_write  out  WAYS each  per-way array write enables (one-hot or zero)
- dirty_in  out  1  value written to the dirty array
- lru_write  out  1  update LRU with way_sel as most recently used
- pmem_read / pmem_write  out  1 each  held until pmem_resp
- pmem_resp  in  1  physical-memory completion

## Operation
- States: S_IDLE, S_EVICT, S_FILL, S_FL_CHECK, S_FL_WB. Outputs are combinational from state/inputs; default 0.
- hit_way = lowest set index of hit (multiple hit bits are a datapath error; lowest index wins).
- S_IDLE, read hit: mem_resp=1, lru_write=1, way_sel=hit_way. Stay.
- S_IDLE, write hit: mem_resp=1, lru_write=1, datainmux_sel=1, data_write[hit_way]=1, dirty_write[hit_way]=1, dirty_in=1. Stay.
- S_IDLE, miss (request, hit==0): victim = lowest-index way with valid=0, else lru_victim. Latch into victim_q. If valid[victim]&dirty[victim] go to S_EVICT, else go to S_FILL.
- S_IDLE, flush=1 and no request: go to S_FL_CHECK with flush_set=0, flush_way=0. A CPU request has priority over flush.
- S_EVICT: pmem_write=1, addressmux_sel=01, way_sel=victim_q. On pmem_resp go to S_FILL.
- S_FILL: pmem_read=1, addressmux_sel=00, way_sel=victim_q. On the pmem_resp cycle only: data/tag/valid/dirty_write[victim_q]=1, dirty_in=0, datainmux_sel=0; then go to S_IDLE. The request re-evaluates as a hit there.
- S_FL_CHECK: set_sel=1, way_sel=flush_way. If valid&dirty[flush_way] go to S_FL_WB, else advance.
- S_FL_WB: set_sel=1, pmem_write=1, addressmux_sel=10, way_sel=flush_way. On pmem_resp: dirty_write[flush_way]=1, dirty_in=0, then advance.
- Advance: flush_way increments; on wrap past WAYS-1 it resets to 0 and flush_set increments. If flush_way=WAYS-1 and flush_set=all-ones: flush_done=1, go to S_IDLE, counters reset to 0.
- CPU requests that arrive during a flush are held off; no mem_resp is given until the flush completes.
- A flush still high in S_IDLE after flush_done starts a new walk.
- flush is ignored outside S_IDLE.

## Timing
- Reset: state=S_IDLE, victim_q=0, flush_set=0, flush_way=0. While rst=1 every output is forced 0, including mem_resp on a hit.
- Reset mid-miss or mid-flush: the transaction is abandoned. pmem_read/pmem_write are 0 in the rst cycle.
- Hit: mem_resp in the same cycle as the request (0 extra cycles).
- Clean miss: request cycle, then S_FILL for N cycles until pmem_resp, then S_IDLE hit with mem_resp.
- Dirty miss: adds the S_EVICT occupancy before S_FILL.
- pmem_read and pmem_write are never high together. pmem_resp outside S_EVICT, S_FILL and S_FL_WB is ignored.
- Flush with no dirty lines: 2**SET_BITS*WAYS S_FL_CHECK cycles, flush_done on the last one.

## Test plan
- WAYS=4: read with hit=4'b0100 -> same-cycle mem_resp=1, lru_write=1, way_sel=2, no array writes.
- Write with hit=4'b0001 -> mem_resp=1, data_write=4'b0001, dirty_write=4'b0001, dirty_in=1, datainmux_sel=1.
- Read miss with valid=4'b1011, lru_victim=0 -> victim 2, goes straight to S_FILL. On pmem_resp (3 cycles later): data/tag/valid_write=4'b0100, dirty_in=0. Next cycle in S_IDLE with hit -> mem_resp.
- Write miss with valid=4'b1111, dirty=4'b0010, lru_victim=1 -> S_EVICT with addressmux_sel=01, pmem_write held through 5 wait cycles, then S_FILL, then mem_resp after the fill.
- SET_BITS=2, WAYS=2, dirty only at (set 1, way 1) and (set 3, way 0) -> exactly 2 pmem_write transactions, each clearing dirty. flush_done pulses once after 8 checks; mem_read raised mid-flush is answered only after flush_done.
- rst asserted during S_EVICT -> pmem_write=0 in the rst cycle, state S_IDLE after. A subsequent hit responds normally.

Source files
------------

// File: rtl/cache_control_nway_if.sv
// Bus between the cache controller and its CPU port, datapath arrays and
// physical memory. The slave side is the controller itself.
interface cache_control_nway_if #(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 3
);
  localparam int W = $clog2(WAYS);

  // CPU side
  logic                mem_read;
  logic                mem_write;
  logic                mem_resp;
  logic                flush;
  logic                flush_done;

  // Datapath status for the addressed set
  logic [WAYS-1:0]     hit;
  logic [WAYS-1:0]     valid;
  logic [WAYS-1:0]     dirty;
  logic [W-1:0]        lru_victim;

  // Datapath control
  logic [W-1:0]        way_sel;
  logic                set_sel;
  logic [SET_BITS-1:0] flush_set;
  logic [1:0]          addressmux_sel;
  logic                datainmux_sel;
  logic [WAYS-1:0]     data_write;
  logic [WAYS-1:0]     tag_write;
  logic [WAYS-1:0]     valid_write;
  logic [WAYS-1:0]     dirty_write;
  logic                dirty_in;
  logic                lru_write;

  // Physical memory
  logic                pmem_read;
  logic                pmem_write;
  logic                pmem_resp;

  modport master (
    output mem_read, mem_write, flush, hit, valid, dirty, lru_victim, pmem_resp,
    input  mem_resp, flush_done, way_sel, set_sel, flush_set, addressmux_sel,
           datainmux_sel, data_write, tag_write, valid_write, dirty_write,
           dirty_in, lru_write, pmem_read, pmem_write
  );

  modport slave (
    input  mem_read, mem_write, flush, hit, valid, dirty, lru_victim, pmem_resp,
    output mem_resp, flush_done, way_sel, set_sel, flush_set, addressmux_sel,
           datainmux_sel, data_write, tag_write, valid_write, dirty_write,
           dirty_in, lru_write, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control_nway.sv
// Control FSM for a WAYS-way set-associative write-back / write-allocate cache
// with a flush walk that writes back every dirty line.
//
// state      | meaning
// S_IDLE     | serve hits, pick a victim on a miss, accept a flush
// S_EVICT    | write the dirty victim line back to physical memory
// S_FILL     | read the missing line from physical memory into the victim way
// S_FL_CHECK | inspect (flush_set, flush_way) for a dirty valid line
// S_FL_WB    | write back the dirty line found by S_FL_CHECK
module cache_control_nway #(
  parameter int WAYS     = 2,
  parameter int SET_BITS = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  cache_control_nway_if.slave bus
);
  localparam int W = $clog2(WAYS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVICT,
    S_FILL,
    S_FL_CHECK,
    S_FL_WB
  } state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        victim_q, victim_d;
  logic [W-1:0]        flush_way_q, flush_way_d;
  logic [SET_BITS-1:0] flush_set_q, flush_set_d;

  logic [W-1:0]        hit_way;
  logic [W-1:0]        inv_way;
  logic [W-1:0]        victim_sel;
  logic                any_hit;
  logic                any_inv;
  logic                req;
  logic                advance;
  logic                walk_last;

  function automatic logic [WAYS-1:0] onehot(input logic [W-1:0] way);
    logic [WAYS-1:0] one;
    one = 1;
    return one << way;
  endfunction

  // Priority-encode the hit vector and the first invalid way (lowest index wins)
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit[i]) hit_way = W'(i);
      if (!bus.valid[i]) inv_way = W'(i);
    end
    any_hit    = |bus.hit;
    any_inv    = ~&bus.valid;
    victim_sel = any_inv ? inv_way : bus.lru_victim;
    req        = bus.mem_read | bus.mem_write;
    walk_last  = (flush_way_q == W'(WAYS - 1)) && (&flush_set_q);
  end

  // Next-state and datapath control; reset forces every output low
  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    flush_way_d = flush_way_q;
    flush_set_d = flush_set_q;
    advance     = 1'b0;

    bus.mem_resp       = 1'b0;
    bus.flush_done     = 1'b0;
    bus.way_sel        = '0;
    bus.set_sel        = 1'b0;
    bus.flush_set      = flush_set_q;
    bus.addressmux_sel = 2'b00;
    bus.datainmux_sel  = 1'b0;
    bus.data_write     = '0;
    bus.tag_write      = '0;
    bus.valid_write    = '0;
    bus.dirty_write    = '0;
    bus.dirty_in       = 1'b0;
    bus.lru_write      = 1'b0;
    bus.pmem_read      = 1'b0;
    bus.pmem_write     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (any_hit) begin
            bus.mem_resp  = 1'b1;
            bus.lru_write = 1'b1;
            bus.way_sel   = hit_way;
            if (bus.mem_write) begin
              bus.datainmux_sel = 1'b1;
              bus.data_write    = onehot(hit_way);
              bus.dirty_write   = onehot(hit_way);
              bus.dirty_in      = 1'b1;
            end
          end else begin
            victim_d = victim_sel;
            if (bus.valid[victim_sel] && bus.dirty[victim_sel]) state_d = S_EVICT;
            else                                                state_d = S_FILL;
          end
        end else if (bus.flush) begin
          state_d     = S_FL_CHECK;
          flush_way_d = '0;
          flush_set_d = '0;
        end
      end

      S_EVICT: begin
        bus.pmem_write     = 1'b1;
        bus.addressmux_sel = 2'b01;
        bus.way_sel        = victim_q;
        if (bus.pmem_resp) state_d = S_FILL;
      end

      S_FILL: begin
        bus.pmem_read = 1'b1;
        bus.way_sel   = victim_q;
        if (bus.pmem_resp) begin
          bus.data_write  = onehot(victim_q);
          bus.tag_write   = onehot(victim_q);
          bus.valid_write = onehot(victim_q);
          bus.dirty_write = onehot(victim_q);
          state_d         = S_IDLE;
        end
      end

      S_FL_CHECK: begin
        bus.set_sel = 1'b1;
        bus.way_sel = flush_way_q;
        if (bus.valid[flush_way_q] && bus.dirty[flush_way_q]) state_d = S_FL_WB;
        else                                                  advance = 1'b1;
      end

      S_FL_WB: begin
        bus.set_sel        = 1'b1;
        bus.pmem_write     = 1'b1;
        bus.addressmux_sel = 2'b10;
        bus.way_sel        = flush_way_q;
        if (bus.pmem_resp) begin
          bus.dirty_write = onehot(flush_way_q);
          advance         = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Step the walk to the next way, wrapping into the next set
    if (advance) begin
      if (walk_last) begin
        bus.flush_done = 1'b1;
        state_d        = S_IDLE;
        flush_way_d    = '0;
        flush_set_d    = '0;
      end else if (flush_way_q == W'(WAYS - 1)) begin
        state_d     = S_FL_CHECK;
        flush_way_d = '0;
        flush_set_d = flush_set_q + 1'b1;
      end else begin
        state_d     = S_FL_CHECK;
        flush_way_d = flush_way_q + 1'b1;
      end
    end

    if (rst_i) begin
      state_d     = S_IDLE;
      victim_d    = '0;
      flush_way_d = '0;
      flush_set_d = '0;

      bus.mem_resp       = 1'b0;
      bus.flush_done     = 1'b0;
      bus.way_sel        = '0;
      bus.set_sel        = 1'b0;
      bus.flush_set      = '0;
      bus.addressmux_sel = 2'b00;
      bus.datainmux_sel  = 1'b0;
      bus.data_write     = '0;
      bus.tag_write      = '0;
      bus.valid_write    = '0;
      bus.dirty_write    = '0;
      bus.dirty_in       = 1'b0;
      bus.lru_write      = 1'b0;
      bus.pmem_read      = 1'b0;
      bus.pmem_write     = 1'b0;
    end
  end

  // State, victim and flush-walk registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      victim_q    <= '0;
      flush_way_q <= '0;
      flush_set_q <= '0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      flush_way_q <= flush_way_d;
      flush_set_q <= flush_set_d;
    end
  end
endmodule
